qos_wrr_arbiter: RTL and testbench

- Weighted round-robin scheduler that drains the four per-class (VC0–VC3) output FIFOs of the PCIe QoS datapath onto a single downstream link.
- Generates the FIFO pop strobes and muxes the popped word to a registered output.
- Honours downstream back-pressure.
- Per-class weights are loaded through the same init handshake used by the datapath's main state machine.

---
 rtl/qos_wrr_arbiter.sv | 133 +++++++++++++
 tb/tb_qos_wrr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/qos_wrr_arbiter.sv
// Weighted round-robin drain of four per-class FIFOs onto one downstream link.
// Pop strobes are combinational; the granted word, its class and valid are registered.
module qos_wrr_arbiter #(
  parameter int DATA_WIDTH   = 12,
  parameter int WEIGHT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init,
  input  logic [WEIGHT_WIDTH-1:0] weight0,
  input  logic [WEIGHT_WIDTH-1:0] weight1,
  input  logic [WEIGHT_WIDTH-1:0] weight2,
  input  logic [WEIGHT_WIDTH-1:0] weight3,
  input  logic [3:0]              fifo_empty,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout0,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout1,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout2,
  input  logic [DATA_WIDTH-1:0]   fifo_dataout3,
  input  logic                    down_almost_full,
  output logic [3:0]              pop,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    valid_out,
  output logic [1:0]              grant_idx,
  output logic                    idle_out,
  output logic                    active_out
);

  typedef enum logic [1:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [WEIGHT_WIDTH-1:0] r_weight [4];
  logic [WEIGHT_WIDTH-1:0] r_credit [4];
  logic [1:0]              r_cur;

  logic [WEIGHT_WIDTH-1:0] w_weight_in [4];
  logic [DATA_WIDTH-1:0]   w_head [4];
  logic [3:0]              w_elig;
  logic                    w_found;
  logic [1:0]              w_sel;
  logic [WEIGHT_WIDTH-1:0] w_eff;
  logic [WEIGHT_WIDTH-1:0] w_credit_new;
  logic                    w_pop_go;

  assign w_weight_in[0] = weight0;
  assign w_weight_in[1] = weight1;
  assign w_weight_in[2] = weight2;
  assign w_weight_in[3] = weight3;
  assign w_head[0]      = fifo_dataout0;
  assign w_head[1]      = fifo_dataout1;
  assign w_head[2]      = fifo_dataout2;
  assign w_head[3]      = fifo_dataout3;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_elig
      assign w_elig[gi] = !fifo_empty[gi] && (r_weight[gi] != '0);
    end
  endgenerate

  // An eligible current class keeps the grant, reloading from its weight once
  // its credit is spent; otherwise the next eligible class starts a fresh burst.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_cur;
    w_eff   = r_weight[r_cur];
    if (w_elig[r_cur]) begin
      w_found = 1'b1;
      w_eff   = (r_credit[r_cur] != '0) ? r_credit[r_cur] : r_weight[r_cur];
    end else begin
      for (int k = 1; k < 4; k++) begin
        if (!w_found && w_elig[r_cur + 2'(k)]) begin
          w_found = 1'b1;
          w_sel   = r_cur + 2'(k);
          w_eff   = r_weight[r_cur + 2'(k)];
        end
      end
    end
  end

  assign w_pop_go     = (r_state == S_ACTIVE) && w_found && !down_almost_full && reset && !init;
  assign w_credit_new = w_eff - WEIGHT_WIDTH'(1);
  assign pop          = w_pop_go ? (4'b0001 << w_sel) : 4'b0000;
  assign idle_out     = (r_state == S_IDLE);
  assign active_out   = (r_state == S_ACTIVE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET:  w_state_next = init ? S_INIT : S_IDLE;
      S_INIT:   if (!init) w_state_next = S_IDLE;
      S_IDLE:   if (|w_elig) w_state_next = S_ACTIVE;
      S_ACTIVE: if (!(|w_elig)) w_state_next = S_IDLE;
      default:  w_state_next = S_RESET;
    endcase
    if (init) w_state_next = S_INIT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= S_RESET;
      r_cur     <= 2'd0;
      data_out  <= '0;
      valid_out <= 1'b0;
      grant_idx <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_weight[i] <= WEIGHT_WIDTH'(1);
        r_credit[i] <= '0;
      end
    end else begin
      r_state   <= w_state_next;
      valid_out <= w_pop_go;
      if (r_state == S_INIT) begin
        r_cur <= 2'd0;
        for (int i = 0; i < 4; i++) begin
          r_weight[i] <= w_weight_in[i];
          r_credit[i] <= '0;
        end
      end else begin
        // A class that runs dry gives up whatever burst credit it had left.
        for (int i = 0; i < 4; i++) begin
          if (!w_elig[i]) r_credit[i] <= '0;
        end
        if (w_pop_go) begin
          r_credit[w_sel] <= w_credit_new;
          data_out        <= w_head[w_sel];
          grant_idx       <= w_sel;
          r_cur           <= (w_credit_new == '0) ? w_sel + 2'd1 : w_sel;
        end
      end
    end
  end

endmodule

// File: tb/tb_qos_wrr_arbiter.sv
// Directed bench for qos_wrr_arbiter: FIFO environment model, vector table of
// expected per-cycle pops, and hand-written reset / idle-wakeup sequences.
module tb_qos_wrr_arbiter;
  localparam int DW = 12;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic [WW-1:0] weight0 = '0, weight1 = '0, weight2 = '0, weight3 = '0;
  logic [3:0]    fifo_empty = 4'hF;
  logic [DW-1:0] fifo_dataout0 = '0, fifo_dataout1 = '0, fifo_dataout2 = '0, fifo_dataout3 = '0;
  logic          down_almost_full = 1'b0;
  logic [3:0]    pop;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [1:0]    grant_idx;
  logic          idle_out;
  logic          active_out;

  qos_wrr_arbiter #(.DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .weight0(weight0), .weight1(weight1), .weight2(weight2), .weight3(weight3),
    .fifo_empty(fifo_empty),
    .fifo_dataout0(fifo_dataout0), .fifo_dataout1(fifo_dataout1),
    .fifo_dataout2(fifo_dataout2), .fifo_dataout3(fifo_dataout3),
    .down_almost_full(down_almost_full),
    .pop(pop), .data_out(data_out), .valid_out(valid_out), .grant_idx(grant_idx),
    .idle_out(idle_out), .active_out(active_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       daf;
    logic [3:0] exp_pop;
  } vec_t;

  vec_t          vecs[$];
  int            cnt[4];
  int            seq[4];
  int            exp_seq[4];
  logic [DW-1:0] base[4];
  logic [DW-1:0] last_data;
  logic [3:0]    pop_seen;
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (cnt[i] == 0);
    fifo_dataout0 = base[0] + DW'(seq[0]);
    fifo_dataout1 = base[1] + DW'(seq[1]);
    fifo_dataout2 = base[2] + DW'(seq[2]);
    fifo_dataout3 = base[3] + DW'(seq[3]);
  endtask

  // One clock: pop is captured mid-cycle, the FIFO model reacts after the edge.
  task automatic tick();
    @(negedge clk);
    pop_seen = pop;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i] && cnt[i] > 0) begin
        cnt[i]--;
        seq[i]++;
      end
    end
    drive_fifos();
  endtask

  task automatic add(input logic d, input logic [3:0] p);
    vecs.push_back('{daf: d, exp_pop: p});
  endtask

  task automatic start_scn(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] w2, input logic [WW-1:0] w3,
                           input int c0, input int c1, input int c2, input int c3);
    weight0 = w0; weight1 = w1; weight2 = w2; weight3 = w3;
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2; cnt[3] = c3;
    for (int i = 0; i < 4; i++) begin
      seq[i]     = 0;
      exp_seq[i] = 0;
      base[i]    = DW'((i + 1) * 256);
    end
    drive_fifos();
    down_almost_full = 1'b0;
    init = 1'b1;
    tick();
    chk("init_no_pop", 32'(pop_seen), 32'h0);
    init = 1'b0;
    tick();
    chk("init_to_idle", 32'(idle_out), 32'h1);
  endtask

  task automatic run_range(input int lo, input int hi);
    int g;
    for (int i = lo; i < hi; i++) begin
      down_almost_full = vecs[i].daf;
      tick();
      $display("vec %0d: daf=%0b pop=%b valid=%0b grant=%0d data=%h",
               i, vecs[i].daf, pop_seen, valid_out, grant_idx, data_out);
      chk($sformatf("vec%0d_pop", i), 32'(pop_seen), 32'(vecs[i].exp_pop));
      chk($sformatf("vec%0d_valid", i), 32'(valid_out), 32'(|vecs[i].exp_pop));
      if (|vecs[i].exp_pop) begin
        g = 0;
        for (int b = 0; b < 4; b++) if (vecs[i].exp_pop[b]) g = b;
        last_data = base[g] + DW'(exp_seq[g]);
        exp_seq[g]++;
        chk($sformatf("vec%0d_grant", i), 32'(grant_idx), 32'(g));
      end
      chk($sformatf("vec%0d_data", i), 32'(data_out), 32'(last_data));
    end
    down_almost_full = 1'b0;
  endtask

  initial begin
    int s1, s3, s4, s5, s_end;

    // Weights 3,1,2,1, everything backlogged.
    s1 = vecs.size();
    add(0, 4'b0000);
    add(0, 4'b0001); add(0, 4'b0001); add(0, 4'b0001); add(0, 4'b0010);
    add(0, 4'b0100); add(0, 4'b0100); add(0, 4'b1000);
    add(0, 4'b0001); add(0, 4'b0001); add(0, 4'b0001); add(0, 4'b0010);
    // Same weights, VC1 empty, VC0 holds one word.
    s3 = vecs.size();
    add(0, 4'b0000);
    add(0, 4'b0001); add(0, 4'b0100); add(0, 4'b0100); add(0, 4'b1000);
    add(0, 4'b0100); add(0, 4'b0100); add(0, 4'b1000);
    // Weights 2,2,2,2 with four back-pressured cycles mid-stream.
    s4 = vecs.size();
    add(0, 4'b0000);
    add(0, 4'b0001); add(0, 4'b0001); add(0, 4'b0010); add(0, 4'b0010);
    add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0000); add(1, 4'b0000);
    add(0, 4'b0100); add(0, 4'b0100); add(0, 4'b1000); add(0, 4'b1000);
    add(0, 4'b0001);
    // Weights 1,1,0,1: VC2 disabled.
    s5 = vecs.size();
    add(0, 4'b0000);
    add(0, 4'b0001); add(0, 4'b0010); add(0, 4'b1000);
    add(0, 4'b0001); add(0, 4'b0010); add(0, 4'b1000); add(0, 4'b0001);
    s_end = vecs.size();

    last_data = '0;
    for (int i = 0; i < 4; i++) begin
      cnt[i] = 100; seq[i] = 0; exp_seq[i] = 0; base[i] = DW'((i + 1) * 256);
    end
    drive_fifos();

    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      $display("reset cycle %0d: pop=%b valid=%0b idle=%0b active=%0b", c, pop_seen, valid_out, idle_out, active_out);
      chk("rst_pop", 32'(pop_seen), 32'h0);
      chk("rst_valid", 32'(valid_out), 32'h0);
      chk("rst_idle", 32'(idle_out), 32'h0);
      chk("rst_active", 32'(active_out), 32'h0);
    end
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    reset = 1'b1;

    start_scn(4'd3, 4'd1, 4'd2, 4'd1, 100, 100, 100, 100);
    run_range(s1, s3);
    start_scn(4'd3, 4'd1, 4'd2, 4'd1, 1, 0, 100, 100);
    run_range(s3, s4);
    chk("vc1_never_popped", 32'(seq[1]), 32'h0);
    start_scn(4'd2, 4'd2, 4'd2, 4'd2, 100, 100, 100, 100);
    run_range(s4, s5);
    start_scn(4'd1, 4'd1, 4'd0, 4'd1, 100, 100, 100, 100);
    run_range(s5, s_end);
    chk("vc2_never_popped", 32'(seq[2]), 32'h0);

    // Idle wake-up by a single word on VC3.
    start_scn(4'd1, 4'd1, 4'd1, 4'd1, 0, 0, 0, 0);
    tick();
    chk("empty_pop", 32'(pop_seen), 32'h0);
    chk("empty_idle", 32'(idle_out), 32'h1);
    cnt[3] = 1; base[3] = 12'hB5A;
    drive_fifos();
    tick();
    $display("wake: pop=%b active=%0b", pop_seen, active_out);
    chk("wake_idle_no_pop", 32'(pop_seen), 32'h0);
    chk("wake_active", 32'(active_out), 32'h1);
    tick();
    $display("wake: pop=%b valid=%0b grant=%0d data=%h", pop_seen, valid_out, grant_idx, data_out);
    chk("wake_pop3", 32'(pop_seen), 32'h8);
    chk("wake_valid", 32'(valid_out), 32'h1);
    chk("wake_grant", 32'(grant_idx), 32'h3);
    chk("wake_data", 32'(data_out), 32'hB5A);
    tick();
    chk("wake_done_pop", 32'(pop_seen), 32'h0);
    chk("wake_done_valid", 32'(valid_out), 32'h0);
    chk("wake_back_idle", 32'(idle_out), 32'h1);

    // Reset asserted while streaming.
    start_scn(4'd1, 4'd1, 4'd1, 4'd1, 100, 100, 100, 100);
    tick();
    tick();
    chk("pre_rst_pop", 32'(pop_seen), 32'h1);
    reset = 1'b0;
    tick();
    $display("mid reset: pop=%b valid=%0b data=%h", pop_seen, valid_out, data_out);
    chk("midrst_pop", 32'(pop_seen), 32'h0);
    chk("midrst_valid", 32'(valid_out), 32'h0);
    chk("midrst_data", 32'(data_out), 32'h0);
    chk("midrst_active", 32'(active_out), 32'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_idle", 32'(idle_out), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
